// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between a requester and the signed multiply/divide unit.
interface mul_div_unit_if;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] result;

   modport master (output start, op, a, b, input busy, done, div_by_zero, result);
   modport slave  (input start, op, a, b, output busy, done, div_by_zero, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 signed multiply / 32/32 signed divide, one iteration per cycle
// through a shared 65-bit accumulator operating on operand magnitudes.
module mul_div_unit (
   input logic           clock,
   input logic           reset,
   mul_div_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} stateT;

   stateT       state;
   logic        opReg;
   logic [31:0] aReg;
   logic [31:0] bReg;
   logic        signA;
   logic        signB;
   logic [31:0] operand;
   logic [64:0] acc;
   logic [4:0]  count;
   logic        busyReg;
   logic        doneReg;
   logic        divZeroReg;
   logic [63:0] resultReg;

   logic [31:0] magA;
   logic [31:0] magB;
   logic [64:0] accNext;
   logic [64:0] shifted;
   logic [32:0] sum;
   logic [63:0] fixResult;

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   assign magA = aReg[31] ? -aReg : aReg;
   assign magB = bReg[31] ? -bReg : bReg;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      accNext = acc;
      sum     = acc[64:32] + {1'b0, (acc[0] ? operand : 32'h0)};
      shifted = {acc[63:0], 1'b0};
      if (!opReg) begin
         accNext = {1'b0, sum, acc[31:1]};
      end else if (shifted[64:32] >= {1'b0, operand}) begin
         accNext = {shifted[64:32] - {1'b0, operand}, shifted[31:1], 1'b1};
      end else begin
         accNext = shifted;
      end
   end

   always_comb begin
      fixResult = acc[63:0];
      if (!opReg) begin
         if (signA ^ signB) fixResult = -acc[63:0];
      end else begin
         fixResult[31:0]  = (signA ^ signB) ? -acc[31:0]  : acc[31:0];
         fixResult[63:32] = signA           ? -acc[63:32] : acc[63:32];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         opReg      <= 1'b0;
         aReg       <= '0;
         bReg       <= '0;
         signA      <= 1'b0;
         signB      <= 1'b0;
         operand    <= '0;
         acc        <= '0;
         count      <= '0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
         resultReg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               doneReg <= 1'b0;
               if (bus.start) begin
                  opReg      <= bus.op;
                  aReg       <= bus.a;
                  bReg       <= bus.b;
                  divZeroReg <= 1'b0;
                  busyReg    <= 1'b1;
                  state      <= PREP;
               end
            end
            PREP: begin
               signA <= aReg[31];
               signB <= bReg[31];
               count <= '0;
               if (opReg && (bReg == 32'h0)) begin
                  resultReg  <= {aReg, 32'hFFFF_FFFF};
                  divZeroReg <= 1'b1;
                  busyReg    <= 1'b0;
                  doneReg    <= 1'b1;
                  state      <= DONE;
               end else begin
                  operand <= opReg ? magB : magA;
                  acc     <= {33'h0, (opReg ? magA : magB)};
                  state   <= RUN;
               end
            end
            RUN: begin
               acc   <= accNext;
               count <= count + 5'd1;
               if (count == 5'd31) state <= FIX;
            end
            FIX: begin
               resultReg <= fixResult;
               busyReg   <= 1'b0;
               doneReg   <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               doneReg <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busyReg;
   assign bus.done        = doneReg;
   assign bus.div_by_zero = divZeroReg;
   assign bus.result      = resultReg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic signed reference model.
module tb_mul_div_unit;
   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   mul_div_unit_if bus ();

   mul_div_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] mulRef(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
   endfunction

   function automatic logic [63:0] divRef(input logic [31:0] x, input logic [31:0] y);
      longint      xs;
      longint      ys;
      logic [63:0] q;
      logic [63:0] r;
      if (y == 32'h0) return {x, 32'hFFFF_FFFF};
      xs = longint'($signed(x));
      ys = longint'($signed(y));
      q  = xs / ys;
      r  = xs % ys;
      return {r[31:0], q[31:0]};
   endfunction

   // Issue one operation, scramble inputs after acceptance, optionally poke start mid-run.
   task automatic runOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn, input bit poke);
      logic [63:0] expRes;
      logic        expDz;
      int          expLat;
      int          n;
      bit          seen;
      bit          busyDropped;
      expRes = opIn ? divRef(aIn, bIn) : mulRef(aIn, bIn);
      expDz  = opIn && (bIn == 32'h0);
      expLat = expDz ? 1 : 34;
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = opIn;
      bus.a     = aIn;
      bus.b     = bIn;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.op    = 1'($urandom_range(0, 1));
      bus.a     = $urandom;
      bus.b     = $urandom;
      check("busy_after_accept", {63'h0, bus.busy}, 64'h1);
      check("dz_cleared_on_accept", {63'h0, bus.div_by_zero}, 64'h0);
      n = 0;
      seen = 1'b0;
      busyDropped = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clock);
         #1;
         n++;
         bus.start = poke && (n == 10);
         if (poke && n == 10) begin
            bus.op = ~opIn;
            bus.a  = aIn ^ 32'h5A5A_1234;
            bus.b  = bIn + 32'd3;
         end
         if (bus.done) seen = 1'b1;
         else if (!bus.busy) busyDropped = 1'b1;
      end
      bus.start = 1'b0;
      check("latency", 64'(n), 64'(expLat));
      check("busy_held", {63'h0, busyDropped}, 64'h0);
      check("result", bus.result, expRes);
      check("div_by_zero", {63'h0, bus.div_by_zero}, {63'h0, expDz});
      check("busy_at_done", {63'h0, bus.busy}, 64'h0);
      @(posedge clock);
      #1;
      check("done_single_pulse", {63'h0, bus.done}, 64'h0);
      check("result_hold", bus.result, expRes);
   endtask

   initial begin
      int doneCount;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rop;
      vectors     = 0;
      miscompares = 0;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b0;
      #12;
      check("reset_busy", {63'h0, bus.busy}, 64'h0);
      check("reset_done", {63'h0, bus.done}, 64'h0);
      check("reset_dz", {63'h0, bus.div_by_zero}, 64'h0);
      check("reset_result", bus.result, 64'h0);
      @(negedge clock);
      reset = 1'b1;

      runOp(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      runOp(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      runOp(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      runOp(1'b1, 32'd100, 32'd7, 1'b0);
      runOp(1'b1, 32'h0000_1234, 32'h0, 1'b0);
      runOp(1'b0, 32'd5, 32'd6, 1'b0);
      runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      runOp(1'b1, 32'd7, 32'hFFFF_FFF9, 1'b0);
      runOp(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

      // Abort mid-run: no done may follow, and the next operation must be clean.
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 32'd1000;
      bus.b     = 32'd1000;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (17) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("abort_busy", {63'h0, bus.busy}, 64'h0);
      check("abort_done", {63'h0, bus.done}, 64'h0);
      check("abort_result", bus.result, 64'h0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.done) doneCount++;
      end
      check("abort_no_done", 64'(doneCount), 64'h0);
      runOp(1'b1, 32'hFFFF_FC18, 32'd33, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 6 == 0) rb = 32'h0;
         else if (i % 3 == 1) rb = $urandom_range(1, 20);
         else if (i % 5 == 2) rb = -32'($urandom_range(1, 20));
         runOp(rop, ra, rb, i % 7 == 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
